// File: rtl/ext_irq_ctrl_pkg.sv
// Shared encodings for the external interrupt controller: channel mode
// values, the service FSM state type and the per-channel event function.
package ext_irq_pkg;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } irq_state_e;

  // Event for one channel given its filtered level now and one cycle ago.
  function automatic logic edge_event(input logic [1:0] mode,
                                      input logic       cur,
                                      input logic       prev);
    case (mode)
      MODE_RISE: return cur & ~prev;
      MODE_FALL: return ~cur & prev;
      MODE_BOTH: return cur ^ prev;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/ext_irq_ctrl_debounce.sv
// Single-channel front end: two-flop synchroniser, debounce counter and
// filtered level. The level only changes after DEBOUNCE_CYCLES consecutive
// synced samples that disagree with it.
module irq_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Metastability synchroniser for the asynchronous board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt front end: per-channel debounce, edge/level event
// detection, pending latch, lowest-index priority and claim/complete FSM.
// Optional macro EXT_IRQ_CTRL_OVF_EN adds the sticky per-channel ovf_o flags.
//
// state      | meaning
// ST_IDLE    | irq_o follows enabled pending bits, claim_i is accepted
// ST_SERVICE | a claim is outstanding, irq_o held low until complete_i
module ext_irq_ctrl
  import ext_irq_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic [CHANNELS-1:0]   irq_in,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   enable_i,
  output logic                  irq_o,
  input  logic                  claim_i,
  output logic                  claim_valid_o,
  output logic [ID_W-1:0]       claim_id_o,
  input  logic                  complete_i,
  output logic [CHANNELS-1:0]   pending_o
`ifdef EXT_IRQ_CTRL_OVF_EN
  ,
  output logic [CHANNELS-1:0]   ovf_o
`endif
);

  logic [1:0]          rst_pipe;
  logic                rst_n;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] evt_q;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] clr;
  logic [ID_W-1:0]     winner;
  irq_state_e          state;
  irq_state_e          state_nxt;
  logic                irq;
  logic                accept;
  logic                spurious;

  // Reset asserts immediately and releases two clocks after CPU_RESETN rises.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_pipe <= '0;
    else             rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_deb
    irq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (CLK100MHZ),
      .rst_n (rst_n),
      .raw   (irq_in[g]),
      .level (level[g])
    );
  end

  // Registered event detection against the delayed filtered level.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= '0;
      evt_q   <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < CHANNELS; i++)
        evt_q[i] <= edge_event(mode_i[2*i +: 2], level[i], level_d[i]);
    end
  end

  assign active = pending & enable_i;

  // Lowest enabled pending index wins.
  always_comb begin
    winner = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (active[i]) winner = ID_W'(i);
  end

  // Next state, request output and claim decode.
  always_comb begin
    state_nxt = state;
    irq       = 1'b0;
    accept    = 1'b0;
    spurious  = 1'b0;
    case (state)
      ST_IDLE: begin
        irq = |active;
        if (claim_i) begin
          if (irq) begin
            accept    = 1'b1;
            state_nxt = ST_SERVICE;
          end else begin
            spurious = 1'b1;
          end
        end
      end
      ST_SERVICE: if (complete_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Claim clears only the winning bit.
  always_comb begin
    clr = '0;
    if (accept) clr[winner] = 1'b1;
  end

  // State register, pending latch (set wins over clear) and claim outputs.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pending       <= '0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      state         <= state_nxt;
      pending       <= (pending & ~clr) | (evt_q & enable_i);
      claim_valid_o <= accept | spurious;
      if (accept)        claim_id_o <= winner;
      else if (spurious) claim_id_o <= '0;
    end
  end

  assign irq_o     = irq;
  assign pending_o = pending;

`ifdef EXT_IRQ_CTRL_OVF_EN
  logic [CHANNELS-1:0] ovf_set;
  logic [CHANNELS-1:0] ovf_ret;

  // Overflow: enabled edge event landing on an already pending bit.
  always_comb begin
    ovf_set = '0;
    ovf_ret = '0;
    for (int i = 0; i < CHANNELS; i++)
      ovf_set[i] = evt_q[i] & enable_i[i] & pending[i] &
                   (mode_i[2*i +: 2] != MODE_LEVEL);
    if (state == ST_SERVICE && complete_i) ovf_ret[claim_id_o] = 1'b1;
  end

  // Sticky flags, retired with the claim they belong to.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) ovf_o <= '0;
    else        ovf_o <= (ovf_o & ~ovf_ret) | ovf_set;
  end
`endif

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Scenario bench for ext_irq_ctrl: expected claim ids are queued when a
// claim is driven and checked by a monitor when claim_valid_o pulses.
module tb_ext_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] irq_in;
  logic [7:0] mode_i;
  logic [3:0] enable_i;
  logic       irq_o;
  logic       claim_i;
  logic       claim_valid_o;
  logic [1:0] claim_id_o;
  logic       complete_i;
  logic [3:0] pending_o;
`ifdef EXT_IRQ_CTRL_OVF_EN
  logic [3:0] ovf_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  ext_irq_ctrl #(.CHANNELS(4), .DEBOUNCE_CYCLES(16)) dut (
    .CLK100MHZ     (clk),
    .CPU_RESETN    (rst_b),
    .irq_in        (irq_in),
    .mode_i        (mode_i),
    .enable_i      (enable_i),
    .irq_o         (irq_o),
    .claim_i       (claim_i),
    .claim_valid_o (claim_valid_o),
    .claim_id_o    (claim_id_o),
    .complete_i    (complete_i),
    .pending_o     (pending_o)
`ifdef EXT_IRQ_CTRL_OVF_EN
    ,
    .ovf_o         (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every claim_valid_o pulse must match a queued id.
  always @(negedge clk) begin
    if (claim_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL claim_unexpected: claim_valid_o=1 id=%0d, required no claim", claim_id_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(claim_id_o) !== e) begin
          errors++;
          $display("FAIL claim_id: got %0d, required %0d", claim_id_o, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_irq(input string name, input logic exp);
    checks++;
    if (irq_o !== exp) begin
      errors++;
      $display("FAIL %s: irq_o=%b, required %b", name, irq_o, exp);
    end
  endtask

  task automatic chk_pend(input string name, input logic [3:0] exp);
    checks++;
    if (pending_o !== exp) begin
      errors++;
      $display("FAIL %s: pending_o=%b, required %b", name, pending_o, exp);
    end
  endtask

  task automatic do_claim(input int id);
    exp_q.push_back(id);
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
  endtask

  task automatic do_complete();
    complete_i = 1'b1;
    tick(1);
    complete_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    checks++;
    if (irq_o !== 1'b0 || claim_valid_o !== 1'b0 || claim_id_o !== 2'd0 || pending_o !== 4'd0) begin
      errors++;
      $display("FAIL %s: irq=%b cv=%b id=%0d pend=%b, required all 0",
               name, irq_o, claim_valid_o, claim_id_o, pending_o);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; irq_in = '0; mode_i = '0; enable_i = '0;
    claim_i = 1'b0; complete_i = 1'b0;
    tick(3);
    chk_all_zero("reset_values");
    rst_b = 1'b1;
    tick(3);
    chk_all_zero("after_release");
  endtask

  task automatic test_bounce();
    enable_i = 4'b0001;
    mode_i   = '0;
    for (int p = 0; p < 3; p++) begin
      irq_in[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin tick(1); chk_irq("bounce_high", 1'b0); end
      irq_in[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin tick(1); chk_irq("bounce_low", 1'b0); end
    end
    irq_in[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      chk_irq(c < 20 ? "bounce_early" : "bounce_latency", c == 20);
    end
    chk_pend("bounce_pending", 4'b0001);
    do_claim(0);
    chk_pend("bounce_cleared", 4'b0000);
    chk_irq("bounce_in_service", 1'b0);
    do_complete();
    chk_irq("bounce_done", 1'b0);
  endtask

  task automatic test_priority();
    enable_i = 4'b1111;
    irq_in   = 4'b1011;
    tick(20);
    chk_pend("prio_both_set", 4'b1010);
    chk_irq("prio_irq", 1'b1);
    do_claim(1);
    chk_pend("prio_after_claim1", 4'b1000);
    chk_irq("prio_masked", 1'b0);
    do_complete();
    chk_irq("prio_reassert", 1'b1);
    do_claim(3);
    chk_pend("prio_after_claim3", 4'b0000);
    do_complete();
  endtask

  task automatic test_service_mask();
    irq_in = 4'b0000;
    tick(22);
    irq_in = 4'b0001;
    tick(20);
    do_claim(0);
    irq_in = 4'b0101;
    tick(20);
    chk_irq("svc_irq_low", 1'b0);
    chk_pend("svc_pending", 4'b0100);
    do_complete();
    chk_irq("svc_after_complete", 1'b1);
    do_claim(2);
    do_complete();
  endtask

  task automatic test_modes();
    enable_i = 4'b0000;
    irq_in   = 4'b0000;
    tick(22);
    mode_i = 8'b00_11_10_01;
    irq_in = 4'b0011;
    tick(22);
    chk_pend("modes_disabled", 4'b0000);
    enable_i = 4'b0011;
    irq_in   = 4'b0000;
    tick(20);
    chk_pend("modes_fall_both", 4'b0011);
    do_claim(0);
    do_complete();
    do_claim(1);
    do_complete();
    chk_pend("modes_cleared", 4'b0000);
    enable_i = 4'b0100;
    irq_in   = 4'b0100;
    tick(20);
    chk_pend("level_set", 4'b0100);
    do_claim(2);
    chk_pend("level_set_wins", 4'b0100);
    do_complete();
    irq_in = 4'b0000;
    tick(22);
    do_claim(2);
    chk_pend("level_released", 4'b0000);
    do_complete();
  endtask

  task automatic test_spurious();
    mode_i   = '0;
    enable_i = 4'b0000;
    irq_in   = 4'b0001;
    tick(22);
    chk_irq("disabled_irq", 1'b0);
    chk_pend("disabled_pending", 4'b0000);
    do_claim(0);
    irq_in = 4'b0000;
    tick(22);
    enable_i = 4'b0001;
    irq_in   = 4'b0001;
    tick(20);
    chk_irq("spurious_still_idle", 1'b1);
    do_claim(0);
  endtask

  task automatic test_reset_mid_service();
    enable_i = 4'b1111;
    irq_in   = 4'b0111;
    tick(20);
    chk_pend("mid_pending", 4'b0110);
    chk_irq("mid_in_service", 1'b0);
    rst_b  = 1'b0;
    irq_in = 4'b0000;
    #1;
    chk_all_zero("async_reset");
    tick(3);
    rst_b = 1'b1;
    for (int c = 0; c < 30; c++) begin tick(1); chk_irq("post_reset_quiet", 1'b0); end
    irq_in = 4'b0010;
    tick(20);
    chk_irq("post_reset_edge", 1'b1);
    do_claim(1);
    do_complete();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_priority();
    test_service_mask();
    test_modes();
    test_spurious();
    test_reset_mid_service();
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL claim_missing: %0d claims outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Parametrised external-interrupt front end for the RISC-V SoC top; successor to the single-button BTNC interrupt path.
- Synchronises and debounces CHANNELS asynchronous board inputs (buttons, switches).
- Per-channel edge/level detection with selectable mode; latches pending bits.
- Presents one prioritised interrupt to the core through a claim/complete handshake.

Parameters:
- CHANNELS, 4: number of external interrupt inputs (1..32).
- DEBOUNCE_CYCLES, 16: consecutive stable samples required before the filtered level changes (>=2).
- ID_W, $clog2(CHANNELS) min 1: width of claim_id_o.

Ports:
- CLK100MHZ  in  1  system clock; all logic is on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to CLK100MHZ.
- irq_in  in  CHANNELS  raw asynchronous board inputs.
- mode_i  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 level-high.
- enable_i  in  CHANNELS  per-channel enable mask.
- irq_o  out  1  interrupt request to the core.
- claim_i  in  1  single-cycle claim strobe from the core.
- claim_valid_o  out  1  one-cycle pulse; claim_id_o is valid.
- claim_id_o  out  ID_W  claimed channel index.
- complete_i  in  1  single-cycle end-of-service strobe.
- pending_o  out  CHANNELS  pending register, for debug and LED mirroring.

Behaviour:
- Reset values: irq_o=0, claim_valid_o=0, claim_id_o=0, pending_o=0, state=IDLE.
- Reset also clears the synchroniser flops, the debounce counters and the filtered levels.
- Synchroniser: two flops per channel.
- Debounce: per channel, an up-counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synced value equals the filtered level.
  - When it reaches DEBOUNCE_CYCLES-1, the filtered level toggles and the counter returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Event detection compares the filtered level with its one-cycle-delayed copy, according to mode.
  - Level mode: event is asserted every cycle the filtered level is 1.
- Pending: set on an event when enable_i[i]=1; events on disabled channels are dropped.
  - Pending is cleared only by a claim of that channel.
  - Simultaneous set and claim-clear on the same channel in the same cycle: set wins (the bit stays 1).
- Priority: lowest index among pending & enable_i.
- FSM:
  - IDLE: irq_o = |(pending & enable_i). On claim_i with irq_o=1:
    - register claim_id_o = winner;
    - clear that pending bit;
    - pulse claim_valid_o next cycle;
    - go to IN_SERVICE.
  - IDLE: claim_i with irq_o=0 pulses claim_valid_o with claim_id_o=0. Software treats this as spurious; there is no state change.
  - IN_SERVICE: irq_o=0. Pending keeps accumulating. claim_i is ignored.
  - IN_SERVICE: complete_i returns the FSM to IDLE. irq_o may reassert on the following cycle.
  - complete_i in IDLE is ignored.
- Latency: a stable input edge produces irq_o at 2 (sync) + DEBOUNCE_CYCLES + 1 (edge detect) + 1 (pending) cycles.
- Clearing enable_i[i] masks irq_o contribution combinationally but keeps the pending bit.
- Reset mid-service returns to IDLE and clears all pending bits.

Optional Feature:
- Macro: EXT_IRQ_CTRL_OVF_EN.
- Defined:
  - Adds output ovf_o [CHANNELS].
  - Sticky per-channel flag, set when an enabled event arrives while the pending bit is already 1 (level mode excluded).
  - Cleared when complete_i retires that channel's claim.
  - Reset value 0.
- Undefined: no ovf_o port; repeated events coalesce silently.

Decomposition:
- Package ext_irq_pkg contains:
  - mode encoding localparams MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_LEVEL=2'b11;
  - FSM state encoding ST_IDLE, ST_SERVICE.
- Sub-module irq_debounce: single-channel sync, debounce counter and filtered level.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated CHANNELS times in a generate loop.
- Priority encoder and FSM live in the top block.

Test Plan:
- Bounce rejection: CHANNELS=4, DEBOUNCE_CYCLES=16, mode rising, enable=4'b0001. Toggle irq_in[0] 1/0 every 4 cycles for 3 pulses, then hold 1 -> exactly one pending[0] set; irq_o rises 20 cycles after the final hold; no earlier assertion.
- Priority and claim: events on channels 3 and 1 in the same cycle, all enabled -> claim_i gives claim_id_o=1 and a claim_valid_o pulse; pending_o=4'b1000. After complete_i, a second claim gives claim_id_o=3.
- Service masking: while IN_SERVICE, debounce an event on channel 2 -> irq_o stays 0 and pending_o[2]=1; complete_i -> irq_o=1 the next cycle.
- Modes: channel 0 falling, channel 1 both, channel 2 level. Apply a 1->0 transition on channels 0 and 1 -> both pending set. Channel 2 held high -> pending re-sets the same cycle it is claimed.
- Spurious and disabled: enable=0 and an event on channel 0 -> irq_o=0, pending stays 0. claim_i in IDLE -> claim_valid_o=1, claim_id_o=0, state unchanged.
- Reset mid-service: CPU_RESETN low for 3 cycles while IN_SERVICE with pending_o=4'b0110 -> all outputs 0 immediately (asynchronously). After release, no irq_o until a new debounced edge.
